imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_BYTES, default 262144, byte capacity of the instruction memory being loaded.
REQ-002 Parameter LEN_W, default 18, width of the word-count input.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  one-cycle load request; sampled only in IDLE.
REQ-006 BASE  input  32  byte start address, latched on accepted START.
REQ-007 LEN  input  LEN_W  number of 32-bit words to load, latched on accepted START.
REQ-008 BYTE_IN  input  8  incoming program byte.
REQ-009 BYTE_VALID  input  1  BYTE_IN holds a valid byte.
REQ-010 BYTE_READY  output  1  loader accepts a byte this cycle.
REQ-011 WE  output  1  one-cycle word write strobe to instruction memory.
REQ-012 WADDR  output  32  byte address of the word being written, word-aligned.
REQ-013 WDATA  output  32  little-endian assembled word: first byte in [7:0], fourth byte in [31:24].
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 ERR  output  1  sticky error flag for the last load request.

Function
REQ-017 The loader SHALL use four states: IDLE, COLLECT, WRITE and FIN.
REQ-018 IDLE with START=1 SHALL latch BASE and LEN, clear ERR, clear the word and lane counters, and transition as follows.
- To FIN with ERR=1 if BASE[1:0]!=0, or if BASE+4*LEN > DEPTH_BYTES (computed at 33-bit or wider width, no wrap).
- Else to FIN if LEN=0.
- Else to COLLECT.
REQ-019 A byte SHALL be accepted exactly when BYTE_VALID&&BYTE_READY; BYTE_READY SHALL equal 1 only in COLLECT.
REQ-020 An accepted byte SHALL be stored in lane lane_cnt (bits 8*lane_cnt+7:8*lane_cnt), after which lane_cnt increments modulo 4.
REQ-021 Acceptance of the byte into lane 3 SHALL move to WRITE; WE=1 for exactly that one WRITE cycle.
REQ-022 During the WE cycle, WADDR SHALL equal BASE+4*word_cnt and WDATA SHALL equal the four assembled bytes.
REQ-023 Latency SHALL be one cycle from acceptance of the fourth byte to WE.
REQ-024 WRITE SHALL increment word_cnt and go to FIN if the new word_cnt equals LEN, else back to COLLECT.
REQ-025 FIN SHALL assert DONE for one cycle and return to IDLE; ERR holds until the next accepted START or reset.
REQ-026 START outside IDLE SHALL be ignored; BYTE_VALID without READY SHALL leave the byte unconsumed, with no internal change.
REQ-027 WADDR and WDATA SHALL be held stable outside WE cycles; they are don't-care to the consumer.

Reset
REQ-028 RST=1 SHALL immediately force the following, discarding any partial word and in-progress load.
- State IDLE.
- BYTE_READY=0, WE=0, BUSY=0, DONE=0, ERR=0.
- WADDR=0, WDATA=0.
- Counters zero.
REQ-029 No WE SHALL be produced in the first cycle after RST deasserts.

Structure
REQ-030 A shared package SHALL hold the state encoding (2 bits: IDLE=0, COLLECT=1, WRITE=2, FIN=3) and the DEPTH_BYTES default.
REQ-031 One sub-module, word_packer, SHALL perform the lane shifting and assembly, with clear, byte-enable, byte, lane and word output.

Verification
REQ-032 The bench SHALL cover the following directed scenarios.
- BASE=0, LEN=4, bytes FF,00,00,00, 00,FF,00,00, 00,00,FF,00, 00,00,00,FF, VALID continuous -> four WE pulses:
  - 0x000000FF @0
  - 0x0000FF00 @4
  - 0x00FF0000 @8
  - 0xFF000000 @12
  - then DONE one cycle after the last WE, ERR=0.
- BASE=0x100, LEN=1, bytes 11,22,33,44 with VALID dropped for 3 cycles between each -> single WE, WADDR=0x100, WDATA=0x44332211.
- LEN=0, BASE=0 -> DONE two cycles after START, no WE, BYTE_READY never 1.
- Error cases, each -> no WE, DONE pulse, ERR=1 until next START:
  - BASE=2, LEN=1 (misaligned).
  - BASE=262140, LEN=2 (overflow).
- RST asserted after 2 bytes of a word, then new START BASE=0, LEN=1 with bytes AA,BB,CC,DD -> WDATA=0xDDCCBBAA; no stale bytes appear.
- START pulsed while in COLLECT -> ignored; BASE/LEN unchanged; load completes as originally requested.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, default
// capacity and the start-request range check.
package imem_loader_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_FIN     = 2'd3;

    localparam int unsigned DEPTH_BYTES_DEFAULT = 262144;

    // Evaluated at 64 bits so base + 4*words can never wrap.
    function automatic logic range_bad(input logic [31:0] base, input logic [63:0] words,
                                       input logic [63:0] depth);
        logic [63:0] last;
        last = 64'(base) + (words << 2);
        return (base[1:0] != 2'b00) || (last > depth);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles four bytes into a little-endian word, one lane per accepted byte.
// The word output already includes the byte being written this cycle.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        be,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  lane,
    output logic [31:0] word
);

    logic [31:0] word_q;

    always_comb begin
        word = word_q;
        if (be) begin
            word[{lane, 3'b000} +: 8] = byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (clr) begin
            word_q <= '0;
        end else begin
            word_q <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit instruction-memory writes starting at a word-aligned
// base address, with a range check on every load request.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEFAULT,
    parameter int unsigned LEN_W       = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [31:0]      BASE,
    input  logic [LEN_W-1:0] LEN,
    input  logic [7:0]       BYTE_IN,
    input  logic             BYTE_VALID,
    output logic             BYTE_READY,
    output logic             WE,
    output logic [31:0]      WADDR,
    output logic [31:0]      WDATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      base_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic [1:0]       lane_q;
    logic             err_q;
    logic [31:0]      waddr_q;
    logic [31:0]      wdata_q;
    logic             start_ok;
    logic             accept;
    logic             bad;
    logic [31:0]      pk_word;

    assign start_ok = START && (state_q == ST_IDLE);
    assign accept   = BYTE_VALID && BYTE_READY;
    assign bad      = range_bad(BASE, 64'(LEN), 64'(DEPTH_BYTES));
    assign cnt_inc  = word_cnt_q + LEN_W'(1);

    word_packer u_packer (
        .clk     (CLK),
        .rst     (RST),
        .clr     (start_ok),
        .be      (accept),
        .byte_in (BYTE_IN),
        .lane    (lane_q),
        .word    (pk_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = (bad || (LEN == '0)) ? ST_FIN : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept && (lane_q == 2'd3)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = (cnt_inc == len_q) ? ST_FIN : ST_COLLECT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            err_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q     <= BASE;
                len_q      <= LEN;
                err_q      <= bad;
                word_cnt_q <= '0;
                lane_q     <= '0;
            end
            if (accept) begin
                lane_q <= lane_q + 2'd1;
                // Capture address and data with the last byte so they are
                // valid during the write cycle and held afterwards.
                if (lane_q == 2'd3) begin
                    waddr_q <= base_q + (32'(word_cnt_q) << 2);
                    wdata_q <= pk_word;
                end
            end
            if (state_q == ST_WRITE) begin
                word_cnt_q <= cnt_inc;
            end
        end
    end

    assign BYTE_READY = (state_q == ST_COLLECT);
    assign WE         = (state_q == ST_WRITE);
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = (state_q == ST_FIN);
    assign ERR        = err_q;
    assign WADDR      = waddr_q;
    assign WDATA      = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: word assembly, handshake gaps, empty and
// rejected loads, mid-load reset and ignored restarts.
module tb_imem_loader;

    localparam int unsigned LEN_W = 18;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic [31:0]      BASE = '0;
    logic [LEN_W-1:0] LEN = '0;
    logic [7:0]       BYTE_IN = '0;
    logic             BYTE_VALID = 1'b0;
    logic             BYTE_READY;
    logic             WE;
    logic [31:0]      WADDR;
    logic [31:0]      WDATA;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    int          we_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rdy_cnt  = 0;
    logic        done_err = 1'b0;

    imem_loader #(
        .DEPTH_BYTES (262144),
        .LEN_W       (LEN_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .BASE       (BASE),
        .LEN        (LEN),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .WE         (WE),
        .WADDR      (WADDR),
        .WDATA      (WDATA),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    // Mid-cycle observer of write strobes, completion pulses and ready cycles.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (WE === 1'b1) begin
            we_addr.push_back(WADDR);
            we_data.push_back(WDATA);
            we_cyc.push_back(cyc);
        end
        if (DONE === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = ERR;
        end
        if (BYTE_READY === 1'b1) rdy_cnt = rdy_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic clear_logs();
        we_addr.delete();
        we_data.delete();
        we_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
        rdy_cnt  = 0;
        done_err = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [LEN_W-1:0] l, output int s);
        s     = cyc;
        START = 1'b1;
        BASE  = b;
        LEN   = l;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r;
        repeat (gap) begin
            BYTE_VALID = 1'b0;
            @(posedge CLK);
            #1;
        end
        BYTE_VALID = 1'b1;
        BYTE_IN    = b;
        r = 1'b0;
        for (int i = 0; i < 20 && !r; i++) begin
            @(negedge CLK);
            r = BYTE_READY;
            @(posedge CLK);
            #1;
        end
        BYTE_VALID = 1'b0;
        n_cmp++;
        if (!r) begin
            n_fail++;
            $display("FAIL byte_accept: byte %h got not accepted expected accepted", b);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt == 0; i++) begin
            @(posedge CLK);
            #1;
        end
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({BYTE_READY, WE, BUSY, DONE, ERR} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {BYTE_READY, WE, BUSY, DONE, ERR});
        end
        n_cmp++;
        if (WADDR !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_waddr: got %h expected 00000000", WADDR);
        end
        n_cmp++;
        if (WDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wdata: got %h expected 00000000", WDATA);
        end
        @(negedge CLK);
        RST = 1'b0;
        clear_logs();
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (we_addr.size() != 0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got we=%0d busy=%b expected we=0 busy=0",
                     we_addr.size(), BUSY);
        end
    endtask

    task automatic test_basic();
        int s;
        logic [31:0] exp_d[4];
        exp_d = '{32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000};
        clear_logs();
        do_start(32'h0, 4, s);
        for (int w = 0; w < 4; w++) begin
            for (int l = 0; l < 4; l++) send_byte((l == w) ? 8'hFF : 8'h00, 0);
        end
        wait_done();
        n_cmp++;
        if (we_addr.size() != 4) begin
            n_fail++;
            $display("FAIL basic_we_count: got %0d expected 4", we_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (we_addr[i] !== 32'(i * 4) || we_data[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL basic_word%0d: got %h@%h expected %h@%h", i, we_data[i],
                             we_addr[i], exp_d[i], 32'(i * 4));
                end
            end
            n_cmp++;
            if (we_cyc[3] - we_cyc[0] != 15) begin
                n_fail++;
                $display("FAIL basic_spacing: got %0d expected 15", we_cyc[3] - we_cyc[0]);
            end
            n_cmp++;
            if (done_cyc != we_cyc[3] + 1 || done_err !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_done: got cyc=%0d err=%b expected cyc=%0d err=0",
                         done_cyc, done_err, we_cyc[3] + 1);
            end
        end
    endtask

    task automatic test_gaps();
        int s;
        int c;
        clear_logs();
        do_start(32'h100, 1, s);
        send_byte(8'h11, 3);
        send_byte(8'h22, 3);
        send_byte(8'h33, 3);
        send_byte(8'h44, 3);
        c = cyc;
        wait_done();
        n_cmp++;
        if (we_addr.size() != 1) begin
            n_fail++;
            $display("FAIL gaps_we_count: got %0d expected 1", we_addr.size());
        end else begin
            n_cmp++;
            if (we_addr[0] !== 32'h100 || we_data[0] !== 32'h44332211) begin
                n_fail++;
                $display("FAIL gaps_word: got %h@%h expected 44332211@00000100",
                         we_data[0], we_addr[0]);
            end
            n_cmp++;
            if (we_cyc[0] != c + 1) begin
                n_fail++;
                $display("FAIL gaps_latency: got %0d expected %0d", we_cyc[0], c + 1);
            end
        end
    endtask

    task automatic test_len_zero();
        int s;
        clear_logs();
        do_start(32'h0, 0, s);
        wait_done();
        n_cmp++;
        if (we_addr.size() != 0 || rdy_cnt != 0) begin
            n_fail++;
            $display("FAIL len0_activity: got we=%0d ready=%0d expected 0/0",
                     we_addr.size(), rdy_cnt);
        end
        n_cmp++;
        if (done_cyc != s + 2 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_done: got cyc=%0d err=%b expected cyc=%0d err=0",
                     done_cyc, done_err, s + 2);
        end
    endtask

    task automatic test_errors();
        int s;
        logic [31:0] bases[2];
        logic [LEN_W-1:0] lens[2];
        bases = '{32'h2, 32'd262140};
        lens  = '{LEN_W'(1), LEN_W'(2)};
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            do_start(bases[k], lens[k], s);
            wait_done();
            repeat (3) @(posedge CLK);
            #1;
            n_cmp++;
            if (we_addr.size() != 0 || done_err !== 1'b1) begin
                n_fail++;
                $display("FAIL err%0d_done: got we=%0d err=%b expected we=0 err=1",
                         k, we_addr.size(), done_err);
            end
            n_cmp++;
            if (ERR !== 1'b1 || BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL err%0d_sticky: got err=%b busy=%b expected err=1 busy=0",
                         k, ERR, BUSY);
            end
        end
        // Exactly filling the memory is legal and clears the previous error.
        clear_logs();
        do_start(32'd262140, 1, s);
        n_cmp++;
        if (ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", ERR);
        end
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        wait_done();
        n_cmp++;
        if (we_addr.size() != 1 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fit_result: got we=%0d err=%b expected we=1 err=0",
                     we_addr.size(), done_err);
        end else begin
            n_cmp++;
            if (we_addr[0] !== 32'd262140 || we_data[0] !== 32'h04030201) begin
                n_fail++;
                $display("FAIL fit_word: got %h@%h expected 04030201@0003fffc",
                         we_data[0], we_addr[0]);
            end
        end
    endtask

    task automatic test_midreset();
        int s;
        clear_logs();
        do_start(32'h0, 1, s);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({BYTE_READY, WE, BUSY, DONE, ERR} !== 5'b0 || WADDR !== 32'h0 || WDATA !== 32'h0)
        begin
            n_fail++;
            $display("FAIL midrst_outputs: got ctrl=%b a=%h d=%h expected 00000/0/0",
                     {BYTE_READY, WE, BUSY, DONE, ERR}, WADDR, WDATA);
        end
        @(negedge CLK);
        RST = 1'b0;
        clear_logs();
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (we_addr.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_no_we: got %0d expected 0", we_addr.size());
        end
        do_start(32'h0, 1, s);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        wait_done();
        n_cmp++;
        if (we_addr.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_we_count: got %0d expected 1", we_addr.size());
        end else begin
            n_cmp++;
            if (we_addr[0] !== 32'h0 || we_data[0] !== 32'hDDCCBBAA) begin
                n_fail++;
                $display("FAIL midrst_word: got %h@%h expected ddccbbaa@00000000",
                         we_data[0], we_addr[0]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int s;
        clear_logs();
        do_start(32'h20, 2, s);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        START = 1'b1;
        BASE  = 32'h400;
        LEN   = 1;
        @(posedge CLK);
        #1 START = 1'b0;
        for (int i = 3; i <= 8; i++) send_byte(8'(i), 0);
        wait_done();
        n_cmp++;
        if (we_addr.size() != 2 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_we_count: got we=%0d err=%b expected we=2 err=0",
                     we_addr.size(), done_err);
        end else begin
            n_cmp++;
            if (we_addr[0] !== 32'h20 || we_data[0] !== 32'h04030201) begin
                n_fail++;
                $display("FAIL restart_word0: got %h@%h expected 04030201@00000020",
                         we_data[0], we_addr[0]);
            end
            n_cmp++;
            if (we_addr[1] !== 32'h24 || we_data[1] !== 32'h08070605) begin
                n_fail++;
                $display("FAIL restart_word1: got %h@%h expected 08070605@00000024",
                         we_data[1], we_addr[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len_zero();
        test_errors();
        test_midreset();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
